fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side adapter between the dual-clock FIFO read port (rd/dout/empty) and a valid/ready streaming consumer.
- Runs entirely in the FIFO read clock domain.
- Hides the FIFO's one-cycle read latency with a small prefetch buffer, so the consumer sees a standard stream with full throughput.
- fifo_rd is driven only from registered state, so there is no combinational path from m_ready to the FIFO.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- BUF_DEPTH, 3, prefetch buffer entries; minimum 3 for one word per cycle with a registered-only rd decision.
- OCC_W, $clog2(BUF_DEPTH+1), width of the occupancy output (derived, not overridden).

Ports:
- clock  in  1  read-domain clock; same clock as the FIFO r_clock.
- reset  in  1  synchronous, active-high reset.
- fifo_rd  out  1  read strobe to the FIFO.
- fifo_dout  in  WIDTH  FIFO read data; valid exactly one clock after a cycle with fifo_rd=1 and fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag in the read domain.
- m_valid  out  1  stream data valid.
- m_data  out  WIDTH  stream data (buffer head).
- m_ready  in  1  consumer accept.
- occupancy  out  OCC_W  number of words held in the buffer (excludes the in-flight word).

Behaviour:
- Reset values (asserted on any posedge clock with reset=1): m_valid=0, m_data=0, occupancy=0, internal inflight=0, all buffer entries=0. fifo_rd=0 while reset=1.
- State:
  - circular buffer of BUF_DEPTH entries with head and tail pointers;
  - occ counter, 0..BUF_DEPTH;
  - inflight flag: a FIFO read issued in the previous cycle.
- Issue rule: fifo_rd = !reset && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - Depends only on registered state and fifo_empty.
- Inflight: inflight_next = fifo_rd. The FIFO guarantees a word for every rd asserted while not empty.
- Capture: when inflight=1, write fifo_dout at tail and advance tail, wrapping modulo BUF_DEPTH.
- Pop: when m_valid && m_ready, advance head, wrapping modulo BUF_DEPTH.
- Occupancy update: occ_next = occ + capture − pop.
  - Simultaneous capture and pop leaves occ unchanged.
  - Capture into an empty buffer with no pop makes the word visible next cycle.
- Outputs: m_valid = (occ != 0); m_data = buffer[head]. Both come directly from registers. occupancy = occ.
- Latency:
  - FIFO going non-empty → fifo_rd the same cycle → word in buffer next edge → m_valid=1 the following cycle.
  - Minimum empty-to-m_valid latency is 2 clocks after fifo_empty falls.
- Throughput: with the FIFO always non-empty and m_ready=1, steady state is occ=1, inflight=1, one word per clock, no bubbles.
- Backpressure: with m_ready=0 the buffer fills to BUF_DEPTH, then fifo_rd deasserts. No word is lost or duplicated.
- Ordering: strict FIFO order is preserved across the buffer wrap.
- Boundary conditions:
  - Overflow is impossible by construction (occ + inflight ≤ BUF_DEPTH invariant); the bench asserts it every cycle.
  - m_data is held stable while m_valid=1 and m_ready=0.
  - m_ready while m_valid=0 has no effect.
- Reset mid-operation:
  - A word returned by the FIFO during or immediately after a reset cycle (from an rd issued before reset) is discarded, because inflight is cleared.
  - Buffer contents are dropped.
  - After reset release, the block resumes from empty with fifo_rd governed by the issue rule.

Decomposition:
- Shared package fifo_pkg:
  - WIDTH default and BUF_DEPTH minimum constant (3);
  - occupancy width function clog2(n+1);
  - pointer-increment-with-wrap function, shared with the FIFO code.
- One natural sub-module: skid_buf. It holds the circular buffer, pointers and occ, with push/pop/head interfaces.
- The top level holds the issue rule and the inflight register.

Test Plan:
- Reset check: hold reset 3 cycles with fifo_empty=0 → fifo_rd=0, m_valid=0, m_data=0, occupancy=0 throughout.
- Streaming: FIFO model preloaded with 0x01..0x14 (20 words), m_ready=1 constantly → first m_valid 2 clocks after reset release; 20 consecutive beats 0x01..0x14 with no bubbles; occupancy never exceeds 1.
- Backpressure: FIFO holds 10 words, m_ready=0 for 8 cycles → occupancy=3, fifo_rd=0 and m_data=0x01 stable. Then m_ready=1 → remaining words delivered in order 0x01..0x0A, none lost.
- Random ready: 200 random bytes written, m_ready random at 50% → output sequence equals input sequence; invariant occ+inflight≤3 holds; buffer wraps more than 50 times.
- Sparse source: fifo_empty toggles every 4 cycles, one word per non-empty window → each word appears 2 clocks after fifo_empty falls; m_valid drops between words.
- Mid-stream reset: reset pulsed for 1 cycle while occupancy=2 and inflight=1 → outputs return to reset values. The in-flight word is not presented; after release, delivery resumes from the next FIFO word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, buffer-operation encoding and pointer helpers for the FIFO
// read-side logic.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH    = 8;
  localparam int unsigned BUF_DEPTH_MIN = 3;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  function automatic int unsigned occ_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Small circular prefetch buffer: push at tail, pop at head, registered
// occupancy and valid flag so the stream outputs come straight from flops.
module skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = BUF_DEPTH_MIN,
  parameter int unsigned OCC_W = occ_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [OCC_W-1:0] occ_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  buf_op_e          op;

  // A pop is only honoured while something is held, so a stray ready is inert.
  always_comb begin
    op = buf_op_e'({push_i, pop_i && valid_q});
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (op)
      BUF_PUSH: begin
        tail_d = PTR_W'(ptr_inc_wrap(32'(tail_q), DEPTH));
        occ_d  = occ_q + OCC_W'(1);
      end
      BUF_POP: begin
        head_d = PTR_W'(ptr_inc_wrap(32'(head_q), DEPTH));
        occ_d  = occ_q - OCC_W'(1);
      end
      BUF_BOTH: begin
        tail_d = PTR_W'(ptr_inc_wrap(32'(tail_q), DEPTH));
        head_d = PTR_W'(ptr_inc_wrap(32'(head_q), DEPTH));
      end
      default: ;
    endcase
    valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[PTR_W'(i)] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
      end
    end
  end

  assign head_o  = mem_q[head_q];
  assign valid_o = valid_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter; prefetches ahead of the
// one-cycle read latency so a ready consumer gets one word per clock.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_MIN,
  parameter int unsigned OCC_W     = occ_width(BUF_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic inflight_q, inflight_d;
  logic pop;

  // Counting the in-flight word as already held keeps the buffer from ever
  // overflowing without looking at m_ready.
  always_comb begin
    fifo_rd    = !reset && !fifo_empty &&
                 ((32'(occupancy) + 32'(inflight_q)) < BUF_DEPTH);
    inflight_d = fifo_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign pop = m_valid && m_ready;

  skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_buf (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .head_o      (m_data),
    .valid_o     (m_valid),
    .occ_o       (occupancy)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO source model, scoreboard on stream beats,
// cycle table for reset/backpressure, and sequences for the timing corners.
module tb_fifo_rd_stream;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_rd;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [1:0] occupancy;

  always #5 clock = ~clock;

  fifo_rd_stream #(.WIDTH(8), .BUF_DEPTH(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occupancy  (occupancy)
  );

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       gate = 1'b0;
  logic       tb_infl = 1'b0;
  logic       rst_seen = 1'b1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;
  int         pops = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // FIFO model: data appears one clock after an accepted read.
  always @(posedge clock) begin
    tb_infl  <= fifo_rd;
    rst_seen <= reset;
    if (fifo_rd && !fifo_empty && src_q.size() > 0) fifo_dout <= src_q.pop_front();
  end

  always @(negedge clock) fifo_empty = gate || (src_q.size() == 0);

  // Scoreboard and per-cycle invariants.
  always @(negedge clock) begin
    logic [7:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      check("occ_plus_inflight_le_3", int'((int'(occupancy) + int'(tb_infl)) <= 3), 1);
      if (prev_stall && !rst_seen) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", int'(m_data), int'(e));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       rd;
    logic       vld;
    logic [1:0] occ;
    logic [7:0] data;
  } vec_t;

  vec_t vt[14];

  task automatic reset_on();
    @(posedge clock);
    #1;
    reset   = 1'b1;
    m_ready = 1'b0;
    gate    = 1'b0;
    src_q.delete();
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    pops = 0;
  endtask

  task automatic load(input int n, input logic [7:0] base, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i));
      src_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check(name, exp_q.size(), 0);
    check({name, "_idle"}, int'(m_valid), 0);
  endtask

  initial begin
    int first;
    bit found;

    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int first;
    bit found;

    //            rst   rdy   rd    vld   occ  data
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h01};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h01};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h01};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h01};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h01};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h01};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h01};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h02};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h03};

    // Reset hold and backpressure, cycle by cycle.
    load(10, 8'h01, 1'b0);
    @(posedge clock);
    for (int i = 0; i < 14; i++) begin
      #1;
      reset   = vt[i].rst;
      m_ready = vt[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d_fifo_rd", i), int'(fifo_rd), int'(vt[i].rd));
      check($sformatf("vec%0d_m_valid", i), int'(m_valid), int'(vt[i].vld));
      check($sformatf("vec%0d_occupancy", i), int'(occupancy), int'(vt[i].occ));
      check($sformatf("vec%0d_m_data", i), int'(m_data), int'(vt[i].data));
      @(posedge clock);
    end
    drain("backpressure_drain", 100);
    check("backpressure_beats", pops, 10);

    // Full-rate streaming.
    reset_on();
    load(20, 8'h01, 1'b0);
    m_ready = 1'b1;
    reset   = 1'b0;
    first   = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (m_valid) begin
        first = c;
        break;
      end
    end
    check("stream_first_valid_cycle", first, 2);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("stream_beat%0d_valid", k), int'(m_valid), 1);
      check($sformatf("stream_beat%0d_occ_le1", k), int'(occupancy <= 2'd1), 1);
      if (k < 19) @(negedge clock);
    end
    drain("stream_drain", 50);
    check("stream_beats", pops, 20);

    // Random backpressure over many buffer wraps.
    reset_on();
    load(200, 8'h00, 1'b1);
    reset = 1'b0;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    m_ready = 1'b1;
    drain("random_drain", 50);
    check("random_beats", pops, 200);
    check("random_wraps_gt_50", int'((pops / 3) > 50), 1);

    // Sparse source: one word per non-empty window.
    reset_on();
    gate    = 1'b1;
    reset   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int w = 0; w < 5; w++) begin
      load(1, 8'(8'h50 + 8'(w)), 1'b0);
      repeat (4) @(posedge clock);
      #1;
      gate = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check($sformatf("sparse%0d_gap", w), int'(m_valid), 0);
      @(negedge clock);
      check($sformatf("sparse%0d_valid", w), int'(m_valid), 1);
      check($sformatf("sparse%0d_data", w), int'(m_data), int'(8'h50 + 8'(w)));
      @(negedge clock);
      check($sformatf("sparse%0d_drop", w), int'(m_valid), 0);
      @(posedge clock);
      #1;
      gate = 1'b1;
    end
    check("sparse_beats", pops, 5);

    // Reset pulse with two words buffered and one in flight.
    reset_on();
    load(6, 8'h31, 1'b0);
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (occupancy == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_reach_occ2", int'(found), 1);
    check("midrst_inflight", int'(tb_infl), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_fifo_rd_in_reset", int'(fifo_rd), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q = src_q;
    check("midrst_remaining_words", exp_q.size(), 3);
    @(negedge clock);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_occupancy", int'(occupancy), 0);
    check("midrst_m_data", int'(m_data), 0);
    @(posedge clock);
    #1;
    m_ready = 1'b1;
    drain("midrst_drain", 50);
    check("midrst_beats", pops, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
